// File: rtl/mult_seq_nm_if.sv
// Operand/result handshake bundle for mult_seq_nm; acc_en exists only when MULT_ACC_EN is defined.
interface mult_seq_nm_if #(
    parameter int N = 4,
    parameter int M = 5
);
    logic             in_valid;
    logic             in_ready;
    logic [N-1:0]     A;
    logic [M-1:0]     B;
    logic             a_signed;
    logic             b_signed;
`ifdef MULT_ACC_EN
    logic             acc_en;
`endif
    logic             out_valid;
    logic             out_ready;
    logic [N+M-1:0]   Prod;

`ifdef MULT_ACC_EN
    modport master (output in_valid, A, B, a_signed, b_signed, acc_en, out_ready,
                    input  in_ready, out_valid, Prod);
    modport slave  (input  in_valid, A, B, a_signed, b_signed, acc_en, out_ready,
                    output in_ready, out_valid, Prod);
`else
    modport master (output in_valid, A, B, a_signed, b_signed, out_ready,
                    input  in_ready, out_valid, Prod);
    modport slave  (input  in_valid, A, B, a_signed, b_signed, out_ready,
                    output in_ready, out_valid, Prod);
`endif
endinterface

// File: rtl/mult_seq_nm.sv
// Sequential NxM multiplier, one partial-product row per clock, per-operand signed/unsigned; MULT_ACC_EN adds multiply-accumulate.
// Latency: out_valid rises M edges after the accept edge; issue interval M+2 edges.
// Backpressure: result held in DONE while out_ready=0; in_ready is high only in IDLE.
module mult_seq_nm #(
    parameter int N = 4,
    parameter int M = 5
) (
    input  logic          clk,
    input  logic          rst,
    mult_seq_nm_if.slave  bus
);
    localparam int W  = N + M;
    localparam int CW = (M > 1) ? $clog2(M) : 1;
    localparam logic [CW-1:0] LAST = CW'(M - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t          state, state_nxt;
    logic [W-1:0]    a_ext;
    logic [M-1:0]    b_q;
    logic            b_sgn;
    logic [W-1:0]    acc, acc_nxt, row;
    logic [CW-1:0]   cnt;
    logic [W-1:0]    prod_q;
    logic            accept, last_row;

    assign bus.in_ready  = (state == IDLE);
    assign bus.out_valid = (state == DONE);
    assign bus.Prod      = prod_q;

    assign accept   = bus.in_valid && (state == IDLE);
    assign last_row = (cnt == LAST);

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = RUN;
            RUN:     if (last_row) state_nxt = DONE;
            DONE:    if (bus.out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // The MSB row of a signed multiplier carries negative weight.
    always_comb begin
        row     = a_ext << cnt;
        acc_nxt = acc;
        if (b_q[cnt]) begin
            if (last_row && b_sgn) acc_nxt = acc - row;
            else                   acc_nxt = acc + row;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            a_ext  <= '0;
            b_q    <= '0;
            b_sgn  <= 1'b0;
            acc    <= '0;
            cnt    <= '0;
            prod_q <= '0;
        end else begin
            case (state)
                IDLE: if (accept) begin
                    a_ext <= {{M{bus.A[N-1] & bus.a_signed}}, bus.A};
                    b_q   <= bus.B;
                    b_sgn <= bus.b_signed;
                    cnt   <= '0;
`ifdef MULT_ACC_EN
                    acc   <= bus.acc_en ? prod_q : '0;
`else
                    acc   <= '0;
`endif
                end
                RUN: begin
                    acc <= acc_nxt;
                    cnt <= cnt + 1'b1;
                    if (last_row) prod_q <= acc_nxt;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_mult_seq_nm.sv
// Directed-vector bench for mult_seq_nm (N=4, M=5), default and MULT_ACC_EN builds.
module tb_mult_seq_nm;
    localparam int N = 4;
    localparam int M = 5;
    localparam int W = N + M;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    mult_seq_nm_if #(.N(N), .M(M)) bus ();
    mult_seq_nm #(.N(N), .M(M)) dut (.clk(clk), .rst(rst), .bus(bus));

    int n_chk  = 0;
    int n_fail = 0;
    int cyc    = 0;
    int acc_cyc[$];

    always @(posedge clk) begin
        if (!rst && bus.in_valid && bus.in_ready) acc_cyc.push_back(cyc);
        cyc <= cyc + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [N-1:0] a, input logic [M-1:0] b,
                         input logic as, input logic bs, input logic ae);
        bus.A        = a;
        bus.B        = b;
        bus.a_signed = as;
        bus.b_signed = bs;
`ifdef MULT_ACC_EN
        bus.acc_en   = ae;
`else
        if (ae) bus.a_signed = as;
`endif
    endtask

    task automatic issue(input logic [N-1:0] a, input logic [M-1:0] b,
                         input logic as, input logic bs, input logic ae);
        int t;
        drive(a, b, as, bs, ae);
        bus.in_valid = 1'b1;
        t = 0;
        while (!bus.in_ready && t < 50) begin tick(); t++; end
        tick();
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_valid(output int lat);
        lat = 0;
        while (!bus.out_valid && lat < 50) begin tick(); lat++; end
    endtask

    task automatic run_op(input logic [N-1:0] a, input logic [M-1:0] b,
                          input logic as, input logic bs, input logic ae,
                          input string tag, input logic [W-1:0] exp);
        int lat;
        issue(a, b, as, bs, ae);
        wait_valid(lat);
        chk({tag, "_lat"}, lat, M);
        chk(tag, bus.Prod, exp);
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        chk({tag, "_idle"}, bus.in_ready, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        int n0, bad, seen, lat, t;
        logic [W-1:0] res[$];

        bus.in_valid = 0; bus.out_ready = 0;
        drive('0, '0, 0, 0, 0);

        rst = 1'b1;
        repeat (2) tick();
        chk("rst_in_ready", bus.in_ready, 1);
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_prod", bus.Prod, 0);
        rst = 1'b0;
        tick();

        // mode combinations
        run_op(4'h8, 5'h10, 1, 1, 0, "ss_m8_m16", 9'h080);
        run_op(4'hF, 5'h1F, 0, 0, 0, "uu_15_31",  9'h1D1);
        run_op(4'hF, 5'h1F, 1, 0, 0, "su_m1_31",  9'h1E1);
        run_op(4'hF, 5'h1F, 0, 1, 0, "us_15_m1",  9'h1F1);

        // back-pressure
        issue(4'h3, 5'h05, 0, 0, 0);
        wait_valid(lat);
        chk("bp_lat", lat, M);
        chk("bp_prod", bus.Prod, 9'h00F);
        drive(4'h1, 5'h01, 0, 0, 0);
        bus.in_valid = 1'b1;
        n0 = acc_cyc.size();
        bad = 0;
        repeat (10) begin
            tick();
            if (bus.out_valid !== 1'b1 || bus.Prod !== 9'h00F || bus.in_ready !== 1'b0) bad++;
        end
        chk("bp_hold", bad, 0);
        chk("bp_no_accept", acc_cyc.size() - n0, 0);
        bus.out_ready = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b0;
        chk("bp_release_in_ready", bus.in_ready, 1);
        chk("bp_release_out_valid", bus.out_valid, 0);
        tick();

        // reset in the middle of a signed -7 x 9
        issue(4'h9, 5'h09, 1, 1, 0);
        repeat (2) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mid_rst_out_valid", bus.out_valid, 0);
        chk("mid_rst_prod", bus.Prod, 0);
        chk("mid_rst_in_ready", bus.in_ready, 1);
        seen = 0;
        repeat (10) begin tick(); if (bus.out_valid) seen++; end
        chk("mid_rst_no_result", seen, 0);
        run_op(4'h3, 5'h05, 0, 0, 0, "post_rst_3x5", 9'h00F);

        // back-to-back issue with in_valid held high
        n0 = acc_cyc.size();
        drive(4'h8, 5'h10, 1, 1, 0);
        bus.in_valid = 1'b1;
        bus.out_ready = 1'b1;
        t = 0;
        while (acc_cyc.size() == n0 && t < 20) begin tick(); t++; end
        drive(4'hF, 5'h1F, 0, 0, 0);
        t = 0;
        while (res.size() < 2 && t < 40) begin
            if (bus.out_valid) res.push_back(bus.Prod);
            if (acc_cyc.size() >= n0 + 2) bus.in_valid = 1'b0;
            tick();
            t++;
        end
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b0;
        chk("b2b_accepts", acc_cyc.size() - n0, 2);
        if (acc_cyc.size() >= n0 + 2) chk("b2b_gap", acc_cyc[n0+1] - acc_cyc[n0], M + 2);
        chk("b2b_results", res.size(), 2);
        if (res.size() == 2) begin
            chk("b2b_res0", res[0], 9'h080);
            chk("b2b_res1", res[1], 9'h1D1);
        end
        tick();

        // accumulate chain
        run_op(4'h3, 5'h05, 0, 0, 0, "acc0_3x5", 9'h00F);
`ifdef MULT_ACC_EN
        run_op(4'h2, 5'h07, 0, 0, 1, "acc1_2x7", 9'h01D);
        run_op(4'hF, 5'h01, 1, 1, 1, "acc2_m1x1", 9'h01C);
`else
        run_op(4'h2, 5'h07, 0, 0, 1, "acc1_2x7", 9'h00E);
        run_op(4'hF, 5'h01, 1, 1, 1, "acc2_m1x1", 9'h1FF);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/mult_seq_nm.md
# mult_seq_nm

Sequential, parametrised N×M-bit multiplier that produces one partial-product row per clock and returns a full-width (N+M)-bit product. It is the area-optimised successor to the combinational Baugh-Wooley array multiplier in the NM_mult library. It adds per-operand signed/unsigned mode selection, a valid/ready handshake on both the operand and result sides, and an optional multiply-accumulate feature. It sits between datapath stages that can tolerate multi-cycle latency in exchange for roughly one RCA row of area instead of M−1 rows.

## Interface
- N, 4, width of multiplicand A (≥2)
- M, 5, width of multiplier B (≥2); latency in row cycles
- clk  in  1  clock; all state updates on the rising edge
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  operands present
- in_ready  out  1  block can accept operands; high exactly when the state is IDLE
- A  in  N  multiplicand
- B  in  M  multiplier
- a_signed  in  1  1: A is two's complement; 0: A is unsigned
- b_signed  in  1  1: B is two's complement; 0: B is unsigned
- acc_en  in  1  present only with MULT_ACC_EN; add to the previous result
- out_valid  out  1  Prod holds a new result
- out_ready  in  1  consumer takes the result
- Prod  out  N+M  product, two's complement modulo 2^(N+M)

## Operation
- FSM states: IDLE, RUN, DONE. Reset → IDLE.
- IDLE → RUN on an edge where in_valid && in_ready (the accept edge).
  - At that edge, latch A sign-/zero-extended to N+M bits according to a_signed, plus B, b_signed and acc_en.
  - Clear the working accumulator `acc` to 0. Under MULT_ACC_EN with acc_en=1, load `acc` with the current Prod instead.
  - Clear row counter cnt (width $clog2(M)) to 0.
- RUN, one row per edge k = cnt (0..M−1):
  - If B[k]=0: `acc` is unchanged.
  - If B[k]=1 and not (k==M−1 && b_signed): acc += A_ext<<k.
  - If B[k]=1, k==M−1 and b_signed: acc −= A_ext<<k (Baugh-Wooley MSB row weight).
  - All arithmetic is mod 2^(N+M) and the carry out of bit N+M−1 is discarded.
  - cnt increments each row. On the edge processing k=M−1, go to DONE and load Prod with the final `acc` value.
- DONE: out_valid=1. Prod is stable. A, B and in_valid are ignored.
- DONE → IDLE on an edge where out_valid && out_ready.
- Prod is a dedicated register. It changes only on entry to DONE or on reset, so it keeps the last result through IDLE and RUN.
- Result equals the mathematically exact product for every mode combination, because |A·B| always fits in N+M bits.
- Reset mid-operation: at the rst edge, any state goes to IDLE, cnt=0, `acc`=0, out_valid=0 and Prod=0. The in-flight operation is discarded and produces no result.

## Timing
- Reset values: in_ready=1 (IDLE), out_valid=0, Prod=0.
- Latency: out_valid rises M edges after the accept edge.
- Minimum issue interval: M+2 edges (accept, M rows, release from DONE, IDLE).
- in_ready is combinational from the state only. It has no combinational path from in_valid or out_ready.
- out_valid is registered. No path from out_ready reaches out_valid.
- Back-pressure: DONE holds indefinitely while out_ready=0, with Prod and out_valid stable.
- in_valid asserted during RUN/DONE: operands are not accepted and must be held by the source until in_ready.
- in_valid high on the IDLE edge that directly follows DONE: accepted normally. There is no bypass from DONE into RUN.

## Configuration
- MULT_ACC_EN defined:
  - The acc_en port exists.
  - An accepted operation with acc_en=1 computes Prod_new = Prod_old + A·B mod 2^(N+M), with signedness per operand mode.
  - acc_en=0 behaves as a plain multiply.
- MULT_ACC_EN undefined:
  - No acc_en port.
  - `acc` always starts at 0.
  - Timing is identical in both builds.

## Test plan
- N=4, M=5, a_signed=b_signed=1, A=4'h8 (−8), B=5'h10 (−16) → Prod=9'h080 (128), out_valid exactly 5 edges after accept.
- Unsigned A=4'hF, B=5'h1F → Prod=9'h1D1 (465). Mixed a_signed=1, b_signed=0, A=4'hF (−1), B=5'h1F (31) → Prod=9'h1E1 (−31).
- Back-pressure: hold out_ready=0 for 10 cycles after out_valid → Prod, out_valid and in_ready=0 stay constant, and a new in_valid is not accepted. Release out_ready → IDLE one edge later.
- Reset asserted for one edge at cnt=2 of a signed −7×9 operation → next cycle out_valid=0, Prod=0, in_ready=1, and no result ever appears. A following 3×5 (unsigned) gives 9'h00F.
- Back-to-back: in_valid held high with two operand pairs → second accept occurs exactly M+2 edges after the first, and both results are correct.
- MULT_ACC_EN: unsigned 3×5 (acc_en=0) → 15. Then 2×7 (acc_en=1) → 29. Then signed −1×1 (acc_en=1) → 28. Without the macro, the same sequence gives 15, 14, 9'h1FF.
